// File: rtl/bus_arbiter_if.sv
// Shared-bus signal bundle between the CPU, the PRC and the bus_arbiter.
// slave is the arbiter's view; master is the view of the requesters and the bus.
interface bus_arbiter_if;
    logic [23:0] cpu_address;
    logic [7:0]  cpu_data_out;
    logic        cpu_read;
    logic        cpu_write;
    logic        cpu_bus_idle;
    logic        cpu_wait;

    logic        prc_bus_request;
    logic [23:0] prc_address;
    logic [7:0]  prc_data_out;
    logic        prc_read;
    logic        prc_write;
    logic        prc_bus_ack;

    logic [23:0] bus_address;
    logic [7:0]  bus_data_out;
    logic        bus_read;
    logic        bus_write;
    logic        timeout_flag;

    modport slave (
        input  cpu_address, cpu_data_out, cpu_read, cpu_write, cpu_bus_idle,
        input  prc_bus_request, prc_address, prc_data_out, prc_read, prc_write,
        output cpu_wait, prc_bus_ack,
        output bus_address, bus_data_out, bus_read, bus_write, timeout_flag
    );

    modport master (
        output cpu_address, cpu_data_out, cpu_read, cpu_write, cpu_bus_idle,
        output prc_bus_request, prc_address, prc_data_out, prc_read, prc_write,
        input  cpu_wait, prc_bus_ack,
        input  bus_address, bus_data_out, bus_read, bus_write, timeout_flag
    );
endinterface

// File: rtl/bus_arbiter.sv
// Hands the shared bus between the CPU and the PRC via a halt/grant/release sequence.
// Define BUS_ARB_TIMEOUT_EN to force-revoke PRC grants after TIMEOUT_CYCLES cycles.
module bus_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4095
) (
    input logic          clk,
    input logic          reset,
    bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        CPU_OWN  = 2'd0,
        HALT_REQ = 2'd1,
        PRC_OWN  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;
    logic   cpu_wait_r;
    logic   prc_bus_ack_r;
    logic   expire;
    logic   lockout;
    logic   timeout_flag_r;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [15:0] hold_cnt;

    // Expiry only counts while the PRC still wants the bus; a simultaneous drop is a normal release.
    assign expire = (state == PRC_OWN) && bus.prc_bus_request &&
                    (hold_cnt == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt       <= '0;
            lockout        <= 1'b0;
            timeout_flag_r <= 1'b0;
        end else begin
            hold_cnt <= (state == PRC_OWN) ? hold_cnt + 16'd1 : '0;
            if (expire) begin
                timeout_flag_r <= 1'b1;
                lockout        <= 1'b1;
            end else if (!bus.prc_bus_request) begin
                lockout <= 1'b0;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign expire             = 1'b0;
    assign lockout            = 1'b0;
    assign timeout_flag_r     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= CPU_OWN;
            cpu_wait_r    <= 1'b0;
            prc_bus_ack_r <= 1'b0;
        end else begin
            state         <= state_next;
            // Handshake outputs follow the state one cycle later.
            cpu_wait_r    <= (state != CPU_OWN);
            prc_bus_ack_r <= (state == PRC_OWN);
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            CPU_OWN: begin
                if (bus.prc_bus_request && !lockout) state_next = HALT_REQ;
            end
            HALT_REQ: begin
                if (!bus.prc_bus_request)
                    state_next = CPU_OWN;
                else if (bus.cpu_bus_idle && !bus.cpu_read && !bus.cpu_write)
                    state_next = PRC_OWN;
            end
            PRC_OWN: begin
                if (!bus.prc_bus_request || expire) state_next = RELEASE;
            end
            RELEASE: state_next = CPU_OWN;
            default: state_next = CPU_OWN;
        endcase
    end

    always_comb begin
        bus.bus_address  = bus.cpu_address;
        bus.bus_data_out = bus.cpu_data_out;
        bus.bus_read     = bus.cpu_read;
        bus.bus_write    = bus.cpu_write;
        if (state == PRC_OWN) begin
            bus.bus_address  = bus.prc_address;
            bus.bus_data_out = bus.prc_data_out;
            bus.bus_read     = bus.prc_read;
            bus.bus_write    = bus.prc_write;
        end else if (state == RELEASE) begin
            bus.bus_address  = '0;
            bus.bus_data_out = '0;
            bus.bus_read     = 1'b0;
            bus.bus_write    = 1'b0;
        end
    end

    assign bus.cpu_wait     = cpu_wait_r;
    assign bus.prc_bus_ack  = prc_bus_ack_r;
    assign bus.timeout_flag = timeout_flag_r;
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic against a
// flag-based ownership model; honours BUS_ARB_TIMEOUT_EN (grant limit 8 cycles when defined).
module tb_bus_arbiter;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam int T     = 8;
    localparam bit TO_EN = 1'b1;
`else
    localparam int T     = 4095;
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_arbiter_if bif();

    bus_arbiter #(.TIMEOUT_CYCLES(16'(T))) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    int errors = 0;
    int checks = 0;
    int ack_seen = 0;

    // Model: who holds the bus, plus the one-cycle-late handshake outputs.
    bit m_halting, m_granted, m_releasing, m_locked, m_flag;
    bit e_ack, e_wait;
    int m_held;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_step();
        bit req;
        req = bif.prc_bus_request;
        if (reset) begin
            m_halting = 0; m_granted = 0; m_releasing = 0; m_locked = 0; m_flag = 0;
            e_ack = 0; e_wait = 0; m_held = 0;
        end else begin
            e_ack  = m_granted;
            e_wait = m_halting | m_granted | m_releasing;
            if (!req) m_locked = 0;
            if (m_releasing) begin
                m_releasing = 0;
            end else if (m_granted) begin
                if (!req) begin
                    m_granted = 0; m_releasing = 1;
                end else if (TO_EN && m_held == T - 1) begin
                    m_granted = 0; m_releasing = 1; m_flag = 1; m_locked = 1;
                end else begin
                    m_held++;
                end
            end else if (m_halting) begin
                if (!req) m_halting = 0;
                else if (bif.cpu_bus_idle && !bif.cpu_read && !bif.cpu_write) begin
                    m_halting = 0; m_granted = 1; m_held = 0;
                end
            end else if (req && !m_locked) begin
                m_halting = 1;
            end
        end
    endtask

    task automatic check_all();
        logic [23:0] ea;
        logic [7:0]  ed;
        logic        er, ew;
        if (m_granted) begin
            ea = bif.prc_address; ed = bif.prc_data_out; er = bif.prc_read; ew = bif.prc_write;
        end else if (m_releasing) begin
            ea = '0; ed = '0; er = 1'b0; ew = 1'b0;
        end else begin
            ea = bif.cpu_address; ed = bif.cpu_data_out; er = bif.cpu_read; ew = bif.cpu_write;
        end
        check("prc_bus_ack",  32'(bif.prc_bus_ack),  32'(e_ack));
        check("cpu_wait",     32'(bif.cpu_wait),     32'(e_wait));
        check("timeout_flag", 32'(bif.timeout_flag), 32'(m_flag));
        check("bus_address",  32'(bif.bus_address),  32'(ea));
        check("bus_data_out", 32'(bif.bus_data_out), 32'(ed));
        check("bus_read",     32'(bif.bus_read),     32'(er));
        check("bus_write",    32'(bif.bus_write),    32'(ew));
        ack_seen += int'(bif.prc_bus_ack);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit req, input bit idle, input bit rd, input bit wr);
        bif.prc_bus_request = req;
        bif.cpu_bus_idle    = idle;
        bif.cpu_read        = rd;
        bif.cpu_write       = wr;
        bif.cpu_address     = 24'($urandom);
        bif.cpu_data_out    = 8'($urandom);
        bif.prc_address     = 24'($urandom);
        bif.prc_data_out    = 8'($urandom);
        bif.prc_read        = 1'($urandom);
        bif.prc_write       = 1'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bit req;
        reset = 1'b1;
        drive(0, 0, 0, 0);
        @(negedge clk);
        do_reset();
        do_reset();

        // Idle CPU traffic passes straight through.
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1'($urandom), 1'($urandom));
            tick();
        end

        // Ten-cycle request pulse with the CPU idle.
        ack_seen = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0);
            tick();
        end
        check("pulse_ack_cycles", 32'(ack_seen), 32'((T < 9) ? T : 9));
        check("pulse_wait_clear", 32'(bif.cpu_wait), 32'd0);

        // CPU busy for 20 cycles, then reaches a safe point.
        do_reset();
        ack_seen = 0;
        for (int i = 0; i < 21; i++) begin
            drive(1, 0, 1'($urandom), 1'($urandom));
            tick();
        end
        check("halt_no_ack", 32'(ack_seen), 32'd0);
        check("halt_wait", 32'(bif.cpu_wait), 32'd1);
        drive(1, 1, 0, 0);
        tick();
        tick();
        check("halt_ack_rise", 32'(bif.prc_bus_ack), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0);
            tick();
        end

        // Request withdrawn while still halting.
        ack_seen = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 1);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0);
            tick();
        end
        check("withdraw_no_ack", 32'(ack_seen), 32'd0);
        check("withdraw_wait", 32'(bif.cpu_wait), 32'd0);

        // Reset in the middle of a PRC grant.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0);
            tick();
        end
        check("mid_grant_ack", 32'(bif.prc_bus_ack), 32'd1);
        do_reset();
        check("reset_ack", 32'(bif.prc_bus_ack), 32'd0);
        check("reset_wait", 32'(bif.cpu_wait), 32'd0);
        check("reset_bus_addr", 32'(bif.bus_address), 32'(bif.cpu_address));

        // Request held for 30 cycles: bounded by the timeout when enabled.
        ack_seen = 0;
        for (int i = 0; i < 30; i++) begin
            drive(1, 1, 0, 0);
            tick();
        end
        check("hold_ack_cycles", 32'(ack_seen), 32'(TO_EN ? 8 : 28));
        check("hold_flag", 32'(bif.timeout_flag), 32'(TO_EN));
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0);
            tick();
        end
        ack_seen = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0);
            tick();
        end
        check("regrant_after_drop", 32'(ack_seen), 32'd3);
        do_reset();

        // Random traffic.
        req = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) req = ~req;
            drive(req, $urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd4095, max cycles PRC may hold the bus when BUS_ARB_TIMEOUT_EN is defined.
REQ-002 SHALL have ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous active-high reset
- cpu_address  in  24  CPU bus address
- cpu_data_out  in  8  CPU write data
- cpu_read / cpu_write  in  1 each  CPU strobes
- cpu_bus_idle  in  1  CPU at bus-safe point (no access this or next cycle)
- cpu_wait  out  1  stall CPU
- prc_bus_request  in  1  PRC bus request
- prc_address  in  24  PRC address
- prc_data_out  in  8  PRC write data
- prc_read / prc_write  in  1 each  PRC strobes
- prc_bus_ack  out  1  PRC owns bus
- bus_address  out  24  shared bus address
- bus_data_out  out  8  shared bus write data
- bus_read / bus_write  out  1 each  shared bus strobes
- timeout_flag  out  1  sticky: PRC grant was force-revoked

Function
REQ-003 SHALL implement states CPU_OWN, HALT_REQ, PRC_OWN, RELEASE in a 2-bit state register.
REQ-004 CPU_OWN: prc_bus_request=1 and no pending-drop lockout -> HALT_REQ; else stay.
REQ-005 HALT_REQ: prc_bus_request=0 -> CPU_OWN (request withdrawn); else cpu_bus_idle=1 and cpu_read=0 and cpu_write=0 -> PRC_OWN; else stay.
REQ-006 PRC_OWN: prc_bus_request=0 -> RELEASE; else stay (subject to REQ-013).
REQ-007 RELEASE: unconditionally -> CPU_OWN after exactly one cycle.
REQ-008 cpu_wait SHALL be registered, =1 in HALT_REQ, PRC_OWN, RELEASE; 0 in CPU_OWN.
REQ-009 prc_bus_ack SHALL be registered, =1 only in PRC_OWN.
REQ-010 Latency: request high at edge N with cpu_bus_idle=1 -> prc_bus_ack=1 after edge N+2; request low at edge M -> prc_bus_ack=0 after edge M+1, cpu_wait=0 after edge M+2.
REQ-011 Bus mux SHALL be combinational from state: PRC_OWN selects prc_* signals; CPU_OWN and HALT_REQ select cpu_* signals; RELEASE drives bus_read=0, bus_write=0, bus_address=0, bus_data_out=0.
REQ-012 In PRC_OWN, cpu_read/cpu_write SHALL be ignored; no CPU strobe reaches the bus.
REQ-013 Simultaneous request withdrawal and timeout expiry SHALL take RELEASE without setting timeout_flag.
REQ-014 Request held continuously in CPU_OWN with cpu_bus_idle never asserted SHALL keep HALT_REQ indefinitely (no timeout in HALT_REQ).

Reset
REQ-015 Reset SHALL force state=CPU_OWN, cpu_wait=0, prc_bus_ack=0, timeout_flag=0, timeout counter=0, lockout=0; overrides all other inputs in that cycle.
REQ-016 Reset asserted in PRC_OWN SHALL return bus to CPU on next cycle with no RELEASE cycle.

Configuration
REQ-017 With BUS_ARB_TIMEOUT_EN defined: 16-bit counter clears on entering PRC_OWN, increments each PRC_OWN cycle; on count==TIMEOUT_CYCLES-1 with request still high -> RELEASE, timeout_flag<=1 (sticky until reset), lockout<=1.
REQ-018 Lockout SHALL block CPU_OWN->HALT_REQ until prc_bus_request is sampled 0, then lockout clears.
REQ-019 Without BUS_ARB_TIMEOUT_EN: no counter or lockout logic, timeout_flag tied 0, PRC holds bus indefinitely.

Verification
REQ-020 Reset, idle inputs -> cpu_wait=0, prc_bus_ack=0, bus_* equal cpu_* inputs.
REQ-021 cpu_bus_idle=1, pulse prc_bus_request high 10 cycles -> ack high cycles 3..11, bus_address=prc_address during ack, one RELEASE cycle with bus_read=bus_write=0, cpu_wait low 2 cycles after request drop.
REQ-022 Request with cpu_bus_idle=0 for 20 cycles then 1 -> state HALT_REQ 20 cycles, cpu_wait=1, ack rises 1 cycle after idle sampled.
REQ-023 Request raised then withdrawn in HALT_REQ -> no ack, return to CPU_OWN, cpu_wait=0 next cycle.
REQ-024 BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, request held 30 cycles -> ack exactly 8 cycles, timeout_flag=1, no regrant until request drops and rises again.
REQ-025 Reset asserted mid-PRC_OWN -> next cycle ack=0, cpu_wait=0, timeout_flag=0, bus_* follow cpu_*.
